// File: rtl/dec_pkg.sv
// ----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the registered 4-to-16 hold decoder.
//   CODE_W   : width of the encoded line index (4)
//   LINES    : number of decoded output lines (16)
//   state_t  : decoder FSM states (ST_IDLE, ST_HOLD)
//   onehot16 : maps a 4-bit code to its 16-bit one-hot line vector
// ----------------------------------------------------------------------------
package dec_pkg;

    localparam int CODE_W = 4;
    localparam int LINES  = 16;

    // The state names carry an ST_ prefix so they cannot collide with the
    // top-level HOLD parameter when the package is wildcard-imported.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Single set bit at the position given by the code.
    function automatic logic [LINES-1:0] onehot16(input logic [CODE_W-1:0] code);
        onehot16 = LINES'(1) << code;
    endfunction

endpackage

// File: rtl/dec4_16.sv
// ----------------------------------------------------------------------------
// dec4_16
// Purely combinational 4-to-16 line decoder with enable.
//   i_code [3:0]  : encoded line index
//   i_en          : enable; when low the output is all zeros
//   o_y   [15:0]  : one-hot decoded lines (or zero when disabled)
// ----------------------------------------------------------------------------
module dec4_16
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_en,
    output logic [LINES-1:0]  o_y
);

    // A disabled decoder (no active source upstream) must never raise a line.
    assign o_y = i_en ? onehot16(i_code) : '0;

endmodule

// File: rtl/decoder4_16_hold.sv
// ----------------------------------------------------------------------------
// decoder4_16_hold
// Registered 4-to-16 decoder that holds each decoded line for HOLD cycles.
// Codes arrive through a valid/ready handshake from a priority encoder.
//   HOLD            : cycles each decoded line stays high (1..255)
//   clk             : rising-edge clock
//   rst_n           : asynchronous active-low reset
//   EI              : enable in; low blocks acceptance and aborts a hold
//   in_valid        : a code is presented
//   in_ready        : decoder can accept a code this cycle (combinational)
//   L        [3:0]  : encoded line index
//   GS              : group select, 1 = code valid, 0 = no active source
//   Y        [15:0] : registered one-hot output (or zero)
//   EO              : one-cycle pulse, a code was accepted with GS=0
//   done            : one-cycle pulse, a hold expired without a reload
// ----------------------------------------------------------------------------
module decoder4_16_hold
    import dec_pkg::*;
#(
    parameter int HOLD = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EI,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] L,
    input  logic              GS,
    output logic [LINES-1:0]  Y,
    output logic              EO,
    output logic              done
);

    localparam int CNT_W = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic [LINES-1:0]  r_y;
    logic [LINES-1:0]  w_yNext;
    logic [LINES-1:0]  w_decoded;
    logic              r_eo;
    logic              r_done;
    logic              w_eoNext;
    logic              w_doneNext;
    logic              w_cntZero;
    logic              w_ready;
    logic              w_accept;

    dec4_16 u_dec4_16 (
        .i_code (L),
        .i_en   (GS),
        .o_y    (w_decoded)
    );

    // The last cycle of a hold (cnt==0) is also the reload slot, which is
    // what makes back-to-back codes gapless.
    assign w_cntZero = (r_cnt == '0);
    assign w_ready   = EI & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_cntZero));
    assign w_accept  = in_valid & w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: a hold is entered or reloaded only by a GS=1 accept;
    // dropping EI or reaching the end of the hold returns to idle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && GS) begin
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!EI) begin
                    w_stateNext = ST_IDLE;
                end else if (w_cntZero) begin
                    w_stateNext = (w_accept && GS) ? ST_HOLD : ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered Y, counter and pulses.
    // EO and done default low so each lasts exactly one cycle, and the
    // branches that raise them are mutually exclusive.
    always_comb begin
        w_yNext    = r_y;
        w_cntNext  = r_cnt;
        w_eoNext   = 1'b0;
        w_doneNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (GS) begin
                        w_yNext   = w_decoded;
                        w_cntNext = CNT_LOAD;
                    end else begin
                        w_yNext  = '0;
                        w_eoNext = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!EI) begin
                    w_yNext   = '0;
                    w_cntNext = '0;
                end else if (!w_cntZero) begin
                    w_cntNext = r_cnt - 1'b1;
                end else if (w_accept) begin
                    if (GS) begin
                        w_yNext   = w_decoded;
                        w_cntNext = CNT_LOAD;
                    end else begin
                        w_yNext  = '0;
                        w_eoNext = 1'b1;
                    end
                end else begin
                    w_yNext    = '0;
                    w_doneNext = 1'b1;
                end
            end
            default: begin
                w_yNext   = '0;
                w_cntNext = '0;
            end
        endcase
    end

    // Datapath registers; reset clears Y at once without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_cnt  <= '0;
            r_eo   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_y    <= w_yNext;
            r_cnt  <= w_cntNext;
            r_eo   <= w_eoNext;
            r_done <= w_doneNext;
        end
    end

    assign in_ready = w_ready;
    assign Y        = r_y;
    assign EO       = r_eo;
    assign done     = r_done;

endmodule
